// File: rtl/cam_match_resolver.sv
// -----------------------------------------------------------------------------
// cam_match_resolver
//
// Downstream stage of the 8-entry lookup CAM. This block takes the CAM's raw
// per-entry match vector and the key that produced it. The data passes through
// a two-stage valid/ready pipeline:
//   S1 : registers match_vec / in_key on the input handshake.
//   S2 : computes the result from S1 and registers it:
//        - match count from a balanced adder tree
//        - lowest matching index
//        - hit and multi-match flags
//        The S2 registers drive every out_* port directly.
//
// Optional build macro: CAM_MATCH_STATS_EN
//   Defined   -> saturating hit / miss / multi-hit counters. They update on
//                each output handshake, and clear_stats clears them.
//   Undefined -> the counter ports are tied to 0 and clear_stats is ignored.
//                The port list is the same in both builds.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset (empties the pipeline)
//   in_valid     match_vec / in_key valid
//   in_ready     block accepts input this cycle (combinational from out_ready)
//   match_vec    bit i set = CAM entry i matched
//   in_key       lookup key that produced match_vec
//   out_valid    result valid
//   out_ready    consumer accepts result
//   out_addr     lowest set index of the match vector (0 on miss)
//   out_hit      at least one entry matched
//   out_multi    two or more entries matched
//   out_count    number of matching entries (0..ENTRIES)
//   out_key      key carried alongside the result
//   clear_stats  synchronous clear of the statistics counters
//   hit_cnt      delivered results with exactly one match
//   miss_cnt     delivered results with no match
//   multi_cnt    delivered results with two or more matches
// -----------------------------------------------------------------------------
module cam_match_resolver #(
  parameter int ENTRIES = 8,
  parameter int ADDR_W  = 3,
  parameter int CNT_W   = 4,
  parameter int KEY_W   = 16,
  parameter int STAT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [ENTRIES-1:0] match_vec,
  input  logic [KEY_W-1:0]   in_key,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ADDR_W-1:0]  out_addr,
  output logic               out_hit,
  output logic               out_multi,
  output logic [CNT_W-1:0]   out_count,
  output logic [KEY_W-1:0]   out_key,
  input  logic               clear_stats,
  output logic [STAT_W-1:0]  hit_cnt,
  output logic [STAT_W-1:0]  miss_cnt,
  output logic [STAT_W-1:0]  multi_cnt
);

  // The adder tree works on whole quads. The match vector is zero-padded up to
  // the next multiple of four bits, so any ENTRIES value still builds a
  // balanced tree.
  localparam int NQUAD = (((ENTRIES + 1) / 2) + 1) / 2;
  localparam int NPAIR = 2 * NQUAD;
  localparam int PAD_W = 4 * NQUAD;

  // Balanced popcount: first bit pairs, then quads, then one final sum.
  function automatic logic [CNT_W-1:0] popcount_tree(input logic [ENTRIES-1:0] vec);
    logic [PAD_W-1:0] padded;
    logic [1:0]       pair_sum [NPAIR];
    logic [2:0]       quad_sum [NQUAD];
    logic [CNT_W-1:0] total;
    padded              = {PAD_W{1'b0}};
    padded[ENTRIES-1:0] = vec;
    for (int p = 0; p < NPAIR; p++) begin
      pair_sum[p] = {1'b0, padded[2*p]} + {1'b0, padded[2*p+1]};
    end
    for (int q = 0; q < NQUAD; q++) begin
      quad_sum[q] = {1'b0, pair_sum[2*q]} + {1'b0, pair_sum[2*q+1]};
    end
    total = {CNT_W{1'b0}};
    for (int q = 0; q < NQUAD; q++) begin
      total = total + CNT_W'(quad_sum[q]);
    end
    return total;
  endfunction

  // Lowest-index priority encoder. The scan runs from the top index down, so
  // the lowest set bit is the last one written. An empty vector gives 0.
  function automatic logic [ADDR_W-1:0] lowest_index(input logic [ENTRIES-1:0] vec);
    logic [ADDR_W-1:0] idx;
    idx = {ADDR_W{1'b0}};
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = ADDR_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  // Pipeline state
  logic               s1_valid_r;
  logic [ENTRIES-1:0] s1_vec_r;
  logic [KEY_W-1:0]   s1_key_r;
  logic               s2_valid_r;
  logic [ADDR_W-1:0]  s2_addr_r;
  logic               s2_hit_r;
  logic               s2_multi_r;
  logic [CNT_W-1:0]   s2_count_r;
  logic [KEY_W-1:0]   s2_key_r;

  // Combinational control and S2 next-state values
  logic               s2_adv_s;
  logic               s1_adv_s;
  logic [CNT_W-1:0]   s1_count_s;
  logic [ADDR_W-1:0]  s1_addr_s;
  logic               s1_hit_s;
  logic               s1_multi_s;

  // Advance enables: a stage may load when it is empty or its content leaves.
  always_comb begin
    s2_adv_s = (~s2_valid_r) | out_ready;
    s1_adv_s = (~s1_valid_r) | s2_adv_s;
  end

  assign in_ready = s1_adv_s;

  // Result computation on the S1 contents.
  always_comb begin
    s1_count_s = popcount_tree(s1_vec_r);
    s1_addr_s  = lowest_index(s1_vec_r);
    s1_hit_s   = (s1_count_s != {CNT_W{1'b0}});
    // A count of two or more has some bit set above the LSB.
    s1_multi_s = |s1_count_s[CNT_W-1:1];
  end

  // S1 capture register: loads on the input handshake and holds while blocked.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid_r <= 1'b0;
      s1_vec_r   <= {ENTRIES{1'b0}};
      s1_key_r   <= {KEY_W{1'b0}};
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_vec_r <= match_vec;
        s1_key_r <= in_key;
      end
    end
  end

  // S2 result register: drives the out_* ports and holds steady during a stall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_r <= 1'b0;
      s2_addr_r  <= {ADDR_W{1'b0}};
      s2_hit_r   <= 1'b0;
      s2_multi_r <= 1'b0;
      s2_count_r <= {CNT_W{1'b0}};
      s2_key_r   <= {KEY_W{1'b0}};
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_addr_r  <= s1_addr_s;
        s2_hit_r   <= s1_hit_s;
        s2_multi_r <= s1_multi_s;
        s2_count_r <= s1_count_s;
        s2_key_r   <= s1_key_r;
      end
    end
  end

  assign out_valid = s2_valid_r;
  assign out_addr  = s2_addr_r;
  assign out_hit   = s2_hit_r;
  assign out_multi = s2_multi_r;
  assign out_count = s2_count_r;
  assign out_key   = s2_key_r;

`ifdef CAM_MATCH_STATS_EN
  // Saturating increment: the value sticks at all-ones.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] val);
    if (&val) begin
      return val;
    end else begin
      return val + {{(STAT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  logic [STAT_W-1:0] hit_cnt_r;
  logic [STAT_W-1:0] miss_cnt_r;
  logic [STAT_W-1:0] multi_cnt_r;
  logic              out_fire_s;

  assign out_fire_s = s2_valid_r & out_ready;

  // Statistics counters: one bump per delivered result. A clear wins over a
  // same-cycle bump.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_r   <= {STAT_W{1'b0}};
      miss_cnt_r  <= {STAT_W{1'b0}};
      multi_cnt_r <= {STAT_W{1'b0}};
    end else if (clear_stats) begin
      hit_cnt_r   <= {STAT_W{1'b0}};
      miss_cnt_r  <= {STAT_W{1'b0}};
      multi_cnt_r <= {STAT_W{1'b0}};
    end else if (out_fire_s) begin
      if (!s2_hit_r) begin
        miss_cnt_r <= sat_inc(miss_cnt_r);
      end else if (!s2_multi_r) begin
        hit_cnt_r <= sat_inc(hit_cnt_r);
      end else begin
        multi_cnt_r <= sat_inc(multi_cnt_r);
      end
    end
  end

  assign hit_cnt   = hit_cnt_r;
  assign miss_cnt  = miss_cnt_r;
  assign multi_cnt = multi_cnt_r;
`else
  // Counters are not built. clear_stats still goes to a sink net so the port
  // stays connected to something.
  logic unused_clear_stats_s;

  assign unused_clear_stats_s = clear_stats;
  assign hit_cnt   = {STAT_W{1'b0}};
  assign miss_cnt  = {STAT_W{1'b0}};
  assign multi_cnt = {STAT_W{1'b0}};
`endif

endmodule

// File: tb/tb_cam_match_resolver.sv
// Testbench for cam_match_resolver. It uses a 4-bit statistics width so that
// saturation is reachable. The reference model is a queue of accepted lookups.
// Counts and lowest indices are derived with plain loops over the bits.
module tb_cam_match_resolver;

  localparam int STAT_W   = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;
`ifdef CAM_MATCH_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        match_vec;
  logic [15:0]       in_key;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        out_addr;
  logic              out_hit;
  logic              out_multi;
  logic [3:0]        out_count;
  logic [15:0]       out_key;
  logic              clear_stats;
  logic [STAT_W-1:0] hit_cnt;
  logic [STAT_W-1:0] miss_cnt;
  logic [STAT_W-1:0] multi_cnt;

  logic [24:0] obs;
  logic [11:0] stats_obs;
  assign obs       = {out_addr, out_hit, out_multi, out_count, out_key};
  assign stats_obs = {hit_cnt, miss_cnt, multi_cnt};

  int n_checks = 0;
  int n_errors = 0;

  cam_match_resolver #(
    .ENTRIES(8), .ADDR_W(3), .CNT_W(4), .KEY_W(16), .STAT_W(STAT_W)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .match_vec(match_vec), .in_key(in_key),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_hit(out_hit), .out_multi(out_multi),
    .out_count(out_count), .out_key(out_key),
    .clear_stats(clear_stats),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .multi_cnt(multi_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0]  vec;
    logic [15:0] key;
    int          acc;   // clock edge that captured the lookup
  } item_t;

  item_t mq[$];
  int    edge_n  = 0;
  int    m_hit   = 0;
  int    m_miss  = 0;
  int    m_multi = 0;

  function automatic int ref_count(input logic [7:0] v);
    int c = 0;
    for (int i = 0; i < 8; i++) c += int'(v[i]);
    return c;
  endfunction

  function automatic int ref_addr(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [24:0] exp_result(input logic [7:0] v, input logic [15:0] k);
    int c = ref_count(v);
    return {3'(ref_addr(v)), (c != 0), (c >= 2), 4'(c), k};
  endfunction

  function automatic item_t make_item(input logic [7:0] v, input logic [15:0] k, input int a);
    item_t it;
    it.vec = v; it.key = k; it.acc = a;
    return it;
  endfunction

  // The oldest accepted lookup is visible one edge after its capture edge.
  function automatic bit model_out_valid();
    return (mq.size() > 0) && (edge_n >= mq[0].acc + 1);
  endfunction

  // Two lookups in flight with the consumer stalled means both stages are full.
  function automatic bit model_in_ready();
    return !((mq.size() == 2) && !out_ready);
  endfunction

  function automatic logic [11:0] exp_stats();
    if (STATS_ON) return {4'(m_hit), 4'(m_miss), 4'(m_multi)};
    else return 12'd0;
  endfunction

  // Model update at each edge, using only the bench's own stimulus and state.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_hit   <= 0;
      m_miss  <= 0;
      m_multi <= 0;
    end else begin
      if (model_out_valid() && out_ready) begin
        if (clear_stats) begin
          m_hit <= 0; m_miss <= 0; m_multi <= 0;
        end else if (ref_count(mq[0].vec) == 0) begin
          if (m_miss < STAT_MAX) m_miss <= m_miss + 1;
        end else if (ref_count(mq[0].vec) == 1) begin
          if (m_hit < STAT_MAX) m_hit <= m_hit + 1;
        end else begin
          if (m_multi < STAT_MAX) m_multi <= m_multi + 1;
        end
        if (in_valid && model_in_ready()) mq.push_back(make_item(match_vec, in_key, edge_n + 1));
        mq.delete(0);
      end else begin
        if (clear_stats) begin
          m_hit <= 0; m_miss <= 0; m_multi <= 0;
        end
        if (in_valid && model_in_ready()) mq.push_back(make_item(match_vec, in_key, edge_n + 1));
      end
      edge_n <= edge_n + 1;
    end
  end

  // ---------------- stimulus helper (no checking) ----------------
  task automatic push_vec(input logic [7:0] v, input logic [15:0] k);
    in_valid = 1'b1; match_vec = v; in_key = k;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (obs !== 25'd0) begin n_errors++; $display("FAIL reset_outputs: got %h expected 0", obs); end
    n_checks++;
    if (stats_obs !== 12'd0) begin n_errors++; $display("FAIL reset_stats: got %h expected 0", stats_obs); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_errors++; $display("FAIL reset_release: got valid/ready %b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_single();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; match_vec = 8'b0010_1000; in_key = 16'h00A5;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_latency1: got out_valid %b expected 0", out_valid); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL single_latency2: got out_valid %b expected 1", out_valid); end
    n_checks++;
    if (obs !== {3'd3, 1'b1, 1'b1, 4'd2, 16'h00A5}) begin
      n_errors++; $display("FAIL single_result: got %h expected %h", obs, {3'd3, 1'b1, 1'b1, 4'd2, 16'h00A5});
    end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL single_drain: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  vecs [3];
    logic [24:0] exps [3];
    vecs[0] = 8'h00; exps[0] = {3'd0, 1'b0, 1'b0, 4'd0, 16'hB000};
    vecs[1] = 8'h80; exps[1] = {3'd7, 1'b1, 1'b0, 4'd1, 16'hB001};
    vecs[2] = 8'hFF; exps[2] = {3'd0, 1'b1, 1'b1, 4'd8, 16'hB002};
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 3);
      if (c < 3) begin match_vec = vecs[c]; in_key = 16'hB000 + 16'(c); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== (c >= 2 && c <= 4)) begin
        n_errors++; $display("FAIL b2b_valid[%0d]: got %b expected %b", c, out_valid, (c >= 2 && c <= 4));
      end
      if (c >= 2 && c <= 4) begin
        n_checks++;
        if (obs !== exps[c-2]) begin
          n_errors++; $display("FAIL b2b_result[%0d]: got %h expected %h", c - 2, obs, exps[c-2]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    logic [7:0] vs [4];
    int acc_n = 0;
    int got_n = 0;
    vs[0] = 8'h14; vs[1] = 8'h01; vs[2] = 8'h00; vs[3] = 8'hC0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1; match_vec = vs[acc_n]; in_key = 16'h5A00 + 16'(acc_n);
      @(negedge clk);
      n_checks++;
      if (in_ready !== (c < 2)) begin n_errors++; $display("FAIL stall_in_ready[%0d]: got %b expected %b", c, in_ready, (c < 2)); end
      n_checks++;
      if (out_valid !== (c >= 2)) begin n_errors++; $display("FAIL stall_out_valid[%0d]: got %b expected %b", c, out_valid, (c >= 2)); end
      if (c >= 2) begin
        n_checks++;
        if (obs !== exp_result(vs[0], 16'h5A00)) begin
          n_errors++; $display("FAIL stall_hold[%0d]: got %h expected %h", c, obs, exp_result(vs[0], 16'h5A00));
        end
      end
      if (in_ready) acc_n++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (acc_n != 2) begin n_errors++; $display("FAIL stall_accepts: got %0d expected 2", acc_n); end
    out_ready = 1'b1;
    for (int c = 0; c < 20 && got_n < 4; c++) begin
      in_valid = (acc_n < 4);
      if (acc_n < 4) begin match_vec = vs[acc_n]; in_key = 16'h5A00 + 16'(acc_n); end
      @(negedge clk);
      if (out_valid) begin
        n_checks++;
        if (obs !== exp_result(vs[got_n], 16'h5A00 + 16'(got_n))) begin
          n_errors++; $display("FAIL stall_order[%0d]: got %h expected %h", got_n, obs, exp_result(vs[got_n], 16'h5A00 + 16'(got_n)));
        end
        got_n++;
      end
      if (in_valid && in_ready) acc_n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (got_n != 4) begin n_errors++; $display("FAIL stall_delivered: got %0d expected 4", got_n); end
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_errors++; $display("FAIL stall_no_dup: got out_valid %b expected 0", out_valid); end
  endtask

  task automatic test_async_reset();
    @(posedge clk); #1;
    out_ready = 1'b0;
    push_vec(8'h3C, 16'hDEAD);
    push_vec(8'h81, 16'hBEEF);
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid, in_ready} !== 2'b10) begin
      n_errors++; $display("FAIL areset_full: got valid/ready %b expected 10", {out_valid, in_ready});
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({out_valid, obs} !== 26'd0) begin n_errors++; $display("FAIL areset_immediate: got %h expected 0", {out_valid, obs}); end
    n_checks++;
    if (stats_obs !== 12'd0) begin n_errors++; $display("FAIL areset_stats: got %h expected 0", stats_obs); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      n_errors++; $display("FAIL areset_release: got valid/ready %b expected 01", {out_valid, in_ready});
    end
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b0) begin n_errors++; $display("FAIL areset_stale[%0d]: got out_valid %b expected 0", c, out_valid); end
    end
  endtask

  task automatic test_stats();
    @(posedge clk); #1;
    out_ready = 1'b1; clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    push_vec(8'h00, 16'h0001); push_vec(8'h00, 16'h0002); push_vec(8'h00, 16'h0003);
    push_vec(8'h10, 16'h0004); push_vec(8'h02, 16'h0005); push_vec(8'h11, 16'h0006);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stats_obs !== (STATS_ON ? {4'd2, 4'd3, 4'd1} : 12'd0)) begin
      n_errors++; $display("FAIL stats_mix: got hit/miss/multi %h expected %h", stats_obs, (STATS_ON ? {4'd2, 4'd3, 4'd1} : 12'd0));
    end
    @(posedge clk); #1;
    push_vec(8'h04, 16'h0007);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b1) begin n_errors++; $display("FAIL stats_clr_setup: got out_valid %b expected 1", out_valid); end
    clear_stats = 1'b1;
    @(posedge clk); #1;
    clear_stats = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stats_obs !== 12'd0) begin n_errors++; $display("FAIL stats_clear_wins: got %h expected 0", stats_obs); end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) push_vec(8'h00, 16'(i));
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stats_obs !== (STATS_ON ? {4'd0, 4'd15, 4'd0} : 12'd0)) begin
      n_errors++; $display("FAIL stats_saturate: got %h expected %h", stats_obs, (STATS_ON ? {4'd0, 4'd15, 4'd0} : 12'd0));
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    @(posedge clk); #1;
    for (int c = 0; c < 400; c++) begin
      case ($urandom_range(0, 4))
        0:       v = 8'h00;
        1:       v = 8'hFF;
        2:       v = 8'h01 << $urandom_range(0, 7);
        default: v = 8'($urandom);
      endcase
      in_valid    = ($urandom_range(0, 9) < 7);
      match_vec   = v;
      in_key      = 16'($urandom);
      out_ready   = ($urandom_range(0, 9) < 6);
      clear_stats = ($urandom_range(0, 49) == 0);
      @(negedge clk);
      n_checks++;
      if (out_valid !== model_out_valid()) begin
        n_errors++; $display("FAIL rand_valid[%0d]: got %b expected %b", c, out_valid, model_out_valid());
      end
      n_checks++;
      if (in_ready !== model_in_ready()) begin
        n_errors++; $display("FAIL rand_in_ready[%0d]: got %b expected %b", c, in_ready, model_in_ready());
      end
      if (model_out_valid()) begin
        n_checks++;
        if (obs !== exp_result(mq[0].vec, mq[0].key)) begin
          n_errors++; $display("FAIL rand_result[%0d]: got %h expected %h", c, obs, exp_result(mq[0].vec, mq[0].key));
        end
      end
      n_checks++;
      if (stats_obs !== exp_stats()) begin
        n_errors++; $display("FAIL rand_stats[%0d]: got %h expected %h", c, stats_obs, exp_stats());
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0 || mq.size() != 0) begin
      n_errors++; $display("FAIL rand_drain: got out_valid %b pending %0d expected 0", out_valid, mq.size());
    end
    n_checks++;
    if (stats_obs !== exp_stats()) begin
      n_errors++; $display("FAIL rand_stats_final: got %h expected %h", stats_obs, exp_stats());
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not reach the end in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; match_vec = 8'h00; in_key = 16'h0000;
    out_ready = 1'b0; clear_stats = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_async_reset();
    test_stats();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
